// File: rtl/fmap_buf_pkg.sv
// Shared definitions for the feature-map buffer controller:
// default geometry, read FSM state type and linear-index width helper.
package fmap_buf_pkg;

  localparam int NPIX_DEF     = 1024;
  localparam int CHANNELS_DEF = 16;
  localparam int DATA_W_DEF   = 16;

  // Number of address bits needed to index every stored word.
  function automatic int idx_width(input int npix, input int chans);
    return (npix * chans > 1) ? $clog2(npix * chans) : 1;
  endfunction

  localparam int IDX_W = idx_width(NPIX_DEF, CHANNELS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fmap_ram.sv
// Single-port synchronous RAM with a one-cycle registered read.
// A write does not update the read output, so rdata holds the last read word.
module fmap_ram #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // One access per cycle: store on write, otherwise register the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/fmap_buf_ctrl.sv
// Feature-map buffer controller: fills a single-port RAM from a producer
// stream in channel-major order and serves random reads through an
// IDLE/RD/DATA handshake FSM. Writes always win the RAM port.
// Optional feature: define FMAP_BUF_RD_GATE_EN to make a read wait until its
// target word has been written (or the buffer is full).
module fmap_buf_ctrl #(
  parameter int NPIX     = fmap_buf_pkg::NPIX_DEF,
  parameter int CHANNELS = fmap_buf_pkg::CHANNELS_DEF,
  parameter int DATA_W   = fmap_buf_pkg::DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  input  logic [9:0]               rd_addr,
  input  logic [3:0]               rd_chan,
  input  logic                     rd_addr_valid,
  output logic                     rd_addr_ready,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_data_valid,
  input  logic                     rd_data_ready,
  output logic                     full,
  output logic                     err_ovf,
  output logic                     err_oob
);

  import fmap_buf_pkg::*;

  localparam int TOTAL = NPIX * CHANNELS;
  localparam int AW    = idx_width(NPIX, CHANNELS);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [AW-1:0]     wr_count;
  logic              full_q;
  logic              err_ovf_q;
  logic              err_oob_q;
  logic [9:0]        lat_addr;
  logic [3:0]        lat_chan;
  logic              lat_oob;
  logic              issued;
  logic [DATA_W-1:0] rd_data_q;
  logic [AW-1:0]     lat_idx;
  logic              gate_ok;
  logic              accept;
  logic              rd_step;
  logic              rd_issue;
  logic              wr_en;
  logic              oob_req;
  logic              ram_en;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  generate
    if (DATA_W < 32) begin : g_unused_bits
      logic unused_wr_bits;
      assign unused_wr_bits = ^wr_data[31:DATA_W];
    end
  endgenerate

  assign wr_en   = wr_valid && !full_q && !clear;
  assign oob_req = ({28'd0, rd_chan} >= 32'(CHANNELS)) || ({22'd0, rd_addr} >= 32'(NPIX));
  assign lat_idx = AW'(32'(lat_chan) * 32'(NPIX) + 32'(lat_addr));
  assign accept  = rd_addr_valid && rd_addr_ready;

`ifdef FMAP_BUF_RD_GATE_EN
  assign gate_ok = full_q || (lat_idx < wr_count);
`else
  assign gate_ok = 1'b1;
`endif

  // Out-of-range requests advance without touching the RAM; real reads need a free port.
  assign rd_issue = rd_step && !lat_oob;
  assign ram_en   = wr_en || rd_issue;
  assign ram_addr = wr_en ? wr_count : lat_idx;

  // Read FSM next state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    rd_addr_ready = 1'b0;
    rd_data_valid = 1'b0;
    rd_step       = 1'b0;
    case (state)
      ST_IDLE: begin
        rd_addr_ready = !wr_valid;
        if (rd_addr_valid && !wr_valid) state_nxt = ST_RD;
      end
      ST_RD: begin
        rd_step = !issued && (lat_oob || (!wr_valid && gate_ok));
        if (issued) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        rd_data_valid = 1'b1;
        if (rd_data_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write side: linear fill counter, full flag and overflow error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count  <= '0;
      full_q    <= 1'b0;
      err_ovf_q <= 1'b0;
    end else if (clear) begin
      wr_count  <= '0;
      full_q    <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (wr_valid && full_q) err_ovf_q <= 1'b1;
      if (wr_en) begin
        if (wr_count == AW'(TOTAL - 1)) begin
          wr_count <= '0;
          full_q   <= 1'b1;
        end else begin
          wr_count <= wr_count + 1'b1;
        end
      end
    end
  end

  // Read side: request latch, issue tracking, result register and range error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_chan  <= '0;
      lat_oob   <= 1'b0;
      issued    <= 1'b0;
      rd_data_q <= '0;
      err_oob_q <= 1'b0;
    end else if (clear) begin
      issued    <= 1'b0;
      rd_data_q <= '0;
      err_oob_q <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr <= rd_addr;
        lat_chan <= rd_chan;
        lat_oob  <= oob_req;
        issued   <= 1'b0;
        if (oob_req) err_oob_q <= 1'b1;
      end else if (rd_step) begin
        issued <= 1'b1;
      end
      if (state == ST_RD && issued) begin
        rd_data_q <= lat_oob ? '0 : ram_rdata;
      end
    end
  end

  assign rd_data = rd_data_q;
  assign full    = full_q;
  assign err_ovf = err_ovf_q;
  assign err_oob = err_oob_q;

  fmap_ram #(
    .DEPTH (TOTAL),
    .AW    (AW),
    .DW    (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata (wr_data[DATA_W-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_fmap_buf_ctrl.sv
// Self-checking bench for fmap_buf_ctrl: a 16-channel instance plus an
// 8-channel instance sharing the same stimulus for range-error checks.
module tb_fmap_buf_ctrl;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_chan;
  logic        rd_addr_valid;
  logic        rd_addr_ready;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        rd_data_ready;
  logic        full;
  logic        err_ovf;
  logic        err_oob;
  logic        rd_addr_ready8;
  logic [15:0] rd_data8;
  logic        rd_data_valid8;
  logic        full8;
  logic        err_ovf8;
  logic        err_oob8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  chan;
    logic [9:0]  addr;
    logic [15:0] exp16;
    logic [15:0] exp8;
  } rd_vec_t;

  rd_vec_t vecs [6];

  fmap_buf_ctrl #(.NPIX(1024), .CHANNELS(16), .DATA_W(16)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_chan(rd_chan), .rd_addr_valid(rd_addr_valid),
    .rd_addr_ready(rd_addr_ready), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready), .full(full), .err_ovf(err_ovf), .err_oob(err_oob)
  );

  fmap_buf_ctrl #(.NPIX(1024), .CHANNELS(8), .DATA_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_chan(rd_chan), .rd_addr_valid(rd_addr_valid),
    .rd_addr_ready(rd_addr_ready8), .rd_data(rd_data8), .rd_data_valid(rd_data_valid8),
    .rd_data_ready(rd_data_ready), .full(full8), .err_ovf(err_ovf8), .err_oob(err_oob8)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present a read request, wait (bounded) for acceptance, then drop the request.
  task automatic apply_stimulus(input logic [3:0] chan, input logic [9:0] addr);
    rd_chan       = chan;
    rd_addr       = addr;
    rd_addr_valid = 1'b1;
    #1;
    for (int k = 0; k < 50; k++) begin
      if (rd_addr_ready) break;
      step();
    end
    check_output("accept_ready", 32'(rd_addr_ready), 32'd1);
    step();
    rd_addr_valid = 1'b0;
  endtask

  task automatic wait_data(input string name);
    for (int k = 0; k < 20; k++) begin
      if (rd_data_valid) break;
      step();
    end
    check_output(name, 32'(rd_data_valid), 32'd1);
  endtask

  initial begin
    vecs[0] = '{chan: 4'd3,  addr: 10'd5,    exp16: 16'd3077,  exp8: 16'd3077};
    vecs[1] = '{chan: 4'd0,  addr: 10'd0,    exp16: 16'd0,     exp8: 16'd0};
    vecs[2] = '{chan: 4'd15, addr: 10'd1023, exp16: 16'd16383, exp8: 16'd0};
    vecs[3] = '{chan: 4'd7,  addr: 10'd512,  exp16: 16'd7680,  exp8: 16'd7680};
    vecs[4] = '{chan: 4'd1,  addr: 10'd1023, exp16: 16'd2047,  exp8: 16'd2047};
    vecs[5] = '{chan: 4'd8,  addr: 10'd0,    exp16: 16'd8192,  exp8: 16'd0};

    rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_addr = '0; rd_chan = '0; rd_addr_valid = 1'b0; rd_data_ready = 1'b1;
    step();
    step();
    check_output("rst_addr_ready", 32'(rd_addr_ready), 32'd1);
    check_output("rst_data_valid", 32'(rd_data_valid), 32'd0);
    check_output("rst_data", 32'(rd_data), 32'd0);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_err_ovf", 32'(err_ovf), 32'd0);
    check_output("rst_err_oob", 32'(err_oob), 32'd0);
    rst = 1'b0;
    step();

    // Fill the whole buffer with wr_data = index.
    for (int i = 0; i < 16383; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(i);
      if (i == 0) begin
        #1;
        check_output("ready_blocked_by_write", 32'(rd_addr_ready), 32'd0);
      end
      step();
    end
    check_output("full_before_last", 32'(full), 32'd0);
    wr_data = 32'd16383;
    step();
    wr_valid = 1'b0;
    check_output("full_after_last", 32'(full), 32'd1);
    check_output("err_ovf_after_fill", 32'(err_ovf), 32'd0);
    check_output("full8", 32'(full8), 32'd1);
    check_output("err_ovf8", 32'(err_ovf8), 32'd1);

    // Table-driven reads with exact minimum-latency checks.
    for (int v = 0; v < 6; v++) begin
      rd_chan       = vecs[v].chan;
      rd_addr       = vecs[v].addr;
      rd_addr_valid = 1'b1;
      rd_data_ready = 1'b1;
      #1;
      check_output("tbl_addr_ready", 32'(rd_addr_ready), 32'd1);
      step();
      rd_addr_valid = 1'b0;
      check_output("tbl_valid_n", 32'(rd_data_valid), 32'd0);
      step();
      check_output("tbl_valid_n1", 32'(rd_data_valid), 32'd0);
      step();
      check_output("tbl_valid_n2", 32'(rd_data_valid), 32'd1);
      check_output("tbl_data", 32'(rd_data), 32'(vecs[v].exp16));
      check_output("tbl_valid8", 32'(rd_data_valid8), 32'd1);
      check_output("tbl_data8", 32'(rd_data8), 32'(vecs[v].exp8));
      step();
      check_output("tbl_back_idle", 32'(rd_data_valid), 32'd0);
    end
    check_output("err_oob_in_range", 32'(err_oob), 32'd0);
    check_output("err_oob8", 32'(err_oob8), 32'd1);

    // Write stream held high blocks acceptance; writes during RD stall the read.
    wr_valid      = 1'b1;
    wr_data       = 32'hFFFF;
    rd_chan       = 4'd2;
    rd_addr       = 10'd10;
    rd_addr_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_output("ready_held_low", 32'(rd_addr_ready), 32'd0);
      step();
    end
    wr_valid = 1'b0;
    #1;
    check_output("ready_after_wr_drop", 32'(rd_addr_ready), 32'd1);
    step();
    rd_addr_valid = 1'b0;
    wr_valid      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("rd_stalled_by_write", 32'(rd_data_valid), 32'd0);
    end
    wr_valid = 1'b0;
    wait_data("wr_stall_valid");
    check_output("wr_stall_data", 32'(rd_data), 32'd2058);
    check_output("err_ovf_set", 32'(err_ovf), 32'd1);
    step();

    // Consumer backpressure: result must hold for five cycles.
    rd_data_ready = 1'b0;
    apply_stimulus(4'd5, 10'd100);
    wait_data("bp_valid");
    for (int k = 0; k < 5; k++) begin
      check_output("bp_hold_valid", 32'(rd_data_valid), 32'd1);
      check_output("bp_hold_data", 32'(rd_data), 32'd5220);
      check_output("bp_ready_low", 32'(rd_addr_ready), 32'd0);
      step();
    end
    rd_data_ready = 1'b1;
    step();
    check_output("bp_released", 32'(rd_data_valid), 32'd0);
    check_output("bp_idle_ready", 32'(rd_addr_ready), 32'd1);

    // Clear wins over a same-cycle write and resets all flags.
    wr_valid = 1'b1;
    wr_data  = 32'hBEEF;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    wr_valid = 1'b0;
    check_output("clr_full", 32'(full), 32'd0);
    check_output("clr_err_ovf", 32'(err_ovf), 32'd0);
    check_output("clr_full8", 32'(full8), 32'd0);
    check_output("clr_err_ovf8", 32'(err_ovf8), 32'd0);
    check_output("clr_err_oob8", 32'(err_oob8), 32'd0);
    check_output("clr_data_valid", 32'(rd_data_valid), 32'd0);
    apply_stimulus(4'd0, 10'd0);
    wait_data("clr_rd0_valid");
    check_output("clr_no_write", 32'(rd_data), 32'd0);
    step();
    apply_stimulus(4'd4, 10'd4);
    wait_data("clr_rd1_valid");
    check_output("clr_ram_kept", 32'(rd_data), 32'd4100);
    step();

    // Reset while a read sits in RD: the read must vanish.
    apply_stimulus(4'd2, 10'd3);
    rst = 1'b1;
    #1;
    check_output("rst_mid_valid", 32'(rd_data_valid), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_output("rst_mid_no_valid", 32'(rd_data_valid), 32'd0);
      step();
    end
    check_output("rst_mid_ready", 32'(rd_addr_ready), 32'd1);
    check_output("rst_mid_full", 32'(full), 32'd0);

`ifdef FMAP_BUF_RD_GATE_EN
    // Read-after-write guard: index 100 requested after only 50 writes.
    for (int i = 0; i < 50; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA000 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    apply_stimulus(4'd0, 10'd100);
    for (int i = 50; i < 100; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA000 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_output("gate_stall", 32'(rd_data_valid), 32'd0);
    end
    wr_valid = 1'b1;
    wr_data  = 32'hA000 + 32'd100;
    step();
    wr_valid = 1'b0;
    check_output("gate_not_yet", 32'(rd_data_valid), 32'd0);
    wait_data("gate_valid");
    check_output("gate_data", 32'(rd_data), 32'hA064);
    check_output("gate_data8", 32'(rd_data8), 32'hA064);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
